// File: rtl/tl_ul_sram_responder.sv
// TileLink-UL single-lane SRAM responder.
// Channel A requests are decoded, applied to a word-addressed SRAM, staged for
// one cycle alongside the registered read data, and queued in an in-order
// response FIFO that drives channel D. The minimum request-to-response latency
// is two cycles. Sustained throughput is one request per cycle while d_ready is held.
module tl_ul_sram_responder #(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                SOURCE_W       = 10,
    parameter int                DEPTH_WORDS    = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = 32'h8000_0000,
    parameter int                RSP_FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [2:0]            a_bits_opcode,
    input  logic [2:0]            a_bits_param,
    input  logic [3:0]            a_bits_size,
    input  logic [SOURCE_W-1:0]   a_bits_source,
    input  logic [ADDR_W-1:0]     a_bits_address,
    input  logic [DATA_W/8-1:0]   a_bits_mask,
    input  logic [DATA_W-1:0]     a_bits_data,
    input  logic                  a_bits_corrupt,

    output logic                  d_valid,
    input  logic                  d_ready,
    output logic [2:0]            d_bits_opcode,
    output logic [1:0]            d_bits_param,
    output logic [3:0]            d_bits_size,
    output logic [SOURCE_W-1:0]   d_bits_source,
    output logic [2:0]            d_bits_sink,
    output logic                  d_bits_denied,
    output logic [DATA_W-1:0]     d_bits_data,
    output logic                  d_bits_corrupt,

    output logic [15:0]           denied_count
);

    localparam int MASK_W = DATA_W / 8;
    localparam int BYTE_W = $clog2(MASK_W);
    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int OFF_W  = IDX_W + BYTE_W;
    localparam int PTR_W  = $clog2(RSP_FIFO_DEPTH);
    localparam int CNT_W  = $clog2(RSP_FIFO_DEPTH + 1);

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;

    // One queued D response. The data is already zeroed unless it is a successful Get.
    typedef struct packed {
        logic                is_get;
        logic                denied;
        logic [3:0]          size;
        logic [SOURCE_W-1:0] source;
        logic [DATA_W-1:0]   data;
    } rsp_t;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic               a_fire;
    logic               is_get;
    logic               is_put_full;
    logic               is_put;
    logic               op_ok;
    logic               in_range;
    logic               size_ok;
    logic               misaligned;
    logic               req_denied;
    logic               wr_en;
    logic [IDX_W-1:0]   word_idx;
    logic [BYTE_W-1:0]  align_mask;
    logic [MASK_W-1:0]  byte_we;

    assign a_fire      = a_valid && a_ready;
    assign is_get      = (a_bits_opcode == OP_GET);
    assign is_put_full = (a_bits_opcode == OP_PUT_FULL);
    assign is_put      = is_put_full || (a_bits_opcode == OP_PUT_PARTIAL);
    assign op_ok       = is_get || is_put;

    // BASE_ADDR is aligned to the SRAM size, so the range check reduces to
    // matching the address bits above the SRAM offset. For the same reason, the
    // word index is just the middle slice of the address.
    assign in_range = (a_bits_address[ADDR_W-1:OFF_W] == BASE_ADDR[ADDR_W-1:OFF_W]);
    assign word_idx = a_bits_address[BYTE_W +: IDX_W];
    assign size_ok  = (a_bits_size <= 4'(BYTE_W));

    // Bit gi of the low-address mask must be zero when the transfer spans more than 2^gi bytes.
    generate
        for (genvar gi = 0; gi < BYTE_W; gi++) begin : g_align
            assign align_mask[gi] = (a_bits_size > 4'(gi));
        end
    endgenerate

    assign misaligned = |(a_bits_address[BYTE_W-1:0] & align_mask);

    assign req_denied = !in_range || !size_ok || misaligned || !op_ok
                     || (is_put && a_bits_corrupt)
                     || (is_put_full && !(&a_bits_mask));

    assign wr_en = a_fire && is_put && !req_denied;

    generate
        for (genvar gi = 0; gi < MASK_W; gi++) begin : g_byte_we
            assign byte_we[gi] = wr_en && a_bits_mask[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // SRAM: byte-masked write and registered read, both on the A-fire edge
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH_WORDS];
    logic [DATA_W-1:0] rd_data_reg;

    // Apply the masked write, and capture the read word for the stage-1 response.
    always_ff @(posedge clock) begin
        for (int b = 0; b < MASK_W; b++) begin
            if (byte_we[b]) begin
                mem[word_idx][b*8 +: 8] <= a_bits_data[b*8 +: 8];
            end
        end
        if (a_fire) begin
            rd_data_reg <= mem[word_idx];
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: response metadata aligned with the registered read data
    // ------------------------------------------------------------------
    logic                s1_valid_reg;
    logic                s1_is_get_reg;
    logic                s1_denied_reg;
    logic [3:0]          s1_size_reg;
    logic [SOURCE_W-1:0] s1_source_reg;

    // Capture the accepted request's response fields for one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= a_fire;
            if (a_fire) begin
                s1_is_get_reg <= is_get;
                s1_denied_reg <= req_denied;
                s1_size_reg   <= a_bits_size;
                s1_source_reg <= a_bits_source;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    rsp_t             fifo_mem [RSP_FIFO_DEPTH];
    rsp_t             push_entry;
    rsp_t             head;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W:0]   occupancy;
    logic             push;
    logic             pop;

    assign push = s1_valid_reg;
    assign pop  = d_valid && d_ready;

    assign push_entry.is_get = s1_is_get_reg;
    assign push_entry.denied = s1_denied_reg;
    assign push_entry.size   = s1_size_reg;
    assign push_entry.source = s1_source_reg;
    assign push_entry.data   = (s1_is_get_reg && !s1_denied_reg) ? rd_data_reg : '0;

    // Space is reserved for the response still in stage 1. A same-cycle pop is
    // deliberately not credited, which keeps a_ready off the d_ready path.
    assign occupancy = (CNT_W+1)'(count_reg) + (CNT_W+1)'(s1_valid_reg);
    assign a_ready   = !reset && (occupancy < (CNT_W+1)'(RSP_FIFO_DEPTH));

    // Next pointer and occupancy values. The pointers wrap explicitly, so any depth works.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = (wr_ptr_reg == PTR_W'(RSP_FIFO_DEPTH-1)) ? '0 : wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = (rd_ptr_reg == PTR_W'(RSP_FIFO_DEPTH-1)) ? '0 : rd_ptr_reg + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // FIFO control state. A reset discards everything queued.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // FIFO storage. This needs no reset, because the count qualifies every entry.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= push_entry;
        end
    end

    // The flow control above guarantees room for every stage-1 response.
    assert property (@(posedge clock) disable iff (reset)
        !(push && !pop && (count_reg == CNT_W'(RSP_FIFO_DEPTH))));

    // ------------------------------------------------------------------
    // Channel D
    // ------------------------------------------------------------------
    assign head           = fifo_mem[rd_ptr_reg];
    assign d_valid        = (count_reg != '0);
    assign d_bits_opcode  = head.is_get ? 3'd1 : 3'd0;
    assign d_bits_param   = 2'd0;
    assign d_bits_size    = head.size;
    assign d_bits_source  = head.source;
    assign d_bits_sink    = 3'd0;
    assign d_bits_denied  = head.denied;
    assign d_bits_data    = head.data;
    assign d_bits_corrupt = head.is_get && head.denied;

    logic [15:0] denied_count_reg;

    // Count the denied responses as they leave. The count saturates at all-ones.
    always_ff @(posedge clock) begin
        if (reset) begin
            denied_count_reg <= '0;
        end else if (pop && head.denied && (denied_count_reg != 16'hFFFF)) begin
            denied_count_reg <= denied_count_reg + 16'd1;
        end
    end

    assign denied_count = denied_count_reg;

    // a_bits_param carries no meaning for this responder.
    logic unused_param;
    assign unused_param = ^a_bits_param;

endmodule
